// File: rtl/sobol_sng_if.sv
// Request/result bundle for the Sobol stochastic number generator.
// Master issues en_in/in; slave returns ready/out/en_out.
interface sobol_sng_if;
    logic        en_in;
    logic [7:0]  in;
    logic        ready;
    logic [31:0] out;
    logic        en_out;

    modport master (
        output en_in,
        output in,
        input  ready,
        input  out,
        input  en_out
    );

    modport slave (
        input  en_in,
        input  in,
        output ready,
        output out,
        output en_out
    );
endinterface

// File: rtl/sobol_sng.sv
// Sobol-sequence stochastic number generator: turns an 8-bit
// probability into a 32-sample bitstream word, one word per request.
module sobol_sng #(
    parameter int DIM = 1
) (
    input  logic         clk,
    input  logic         rst,
    sobol_sng_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE,
        GEN,
        DONE
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [7:0]  val;
    logic [7:0]  x;
    logic [4:0]  cnt;
    logic [31:0] sh;
    logic [31:0] out_q;
    logic        bit_b;
    logic [2:0]  c;
    logic [7:0]  v_c;
    logic [7:0]  cnt8;
    logic        last;

    function automatic logic [7:0] dir(input logic [2:0] i);
        logic [7:0] d;
        d = 8'h80 >> i;
        if (DIM == 2) begin
            case (i)
                3'd0:    d = 8'h80;
                3'd1:    d = 8'hC0;
                3'd2:    d = 8'hA0;
                3'd3:    d = 8'hF0;
                3'd4:    d = 8'h88;
                3'd5:    d = 8'hCC;
                3'd6:    d = 8'hAA;
                default: d = 8'hFF;
            endcase
        end
        return d;
    endfunction

    // Sample compare and direction-vector pick from the lowest zero of cnt
    always_comb begin
        bit_b = val > x;
        cnt8  = {3'b000, cnt};
        c     = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (!cnt8[i]) c = 3'(i);
        end
        v_c  = dir(c);
        last = cnt == 5'd31;
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    // Next-state: accept in IDLE/DONE, run 32 samples in GEN
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.en_in) state_nx = GEN;
            GEN:     if (last) state_nx = DONE;
            DONE:    state_nx = bus.en_in ? GEN : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: latch request, step the sequence, collect samples
    always_ff @(posedge clk) begin
        if (!rst) begin
            val   <= 8'd0;
            x     <= 8'd0;
            cnt   <= 5'd0;
            sh    <= 32'd0;
            out_q <= 32'd0;
        end else begin
            case (state)
                GEN: begin
                    sh[cnt] <= bit_b;
                    x       <= x ^ v_c;
                    cnt     <= cnt + 5'd1;
                    if (last) out_q <= sh | {bit_b, 31'd0};
                end
                default: begin
                    if (bus.en_in) begin
                        val <= bus.in;
                        x   <= 8'd0;
                        cnt <= 5'd0;
                        sh  <= 32'd0;
                    end
                end
            endcase
        end
    end

    assign bus.ready  = state != GEN;
    assign bus.en_out = state == DONE;
    assign bus.out    = out_q;

endmodule

// File: tb/tb_sobol_sng.sv
// Bench for sobol_sng: DIM=1 and DIM=2 instances run in lockstep
// against a Gray-code Sobol reference model.
module tb_sobol_sng;

    logic clk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   miscompares = 0;

    sobol_sng_if a ();
    sobol_sng_if b ();

    assign b.en_in = a.en_in;
    assign b.in    = a.in;

    sobol_sng #(.DIM(1)) u1 (.clk(clk), .rst(rst), .bus(a));
    sobol_sng #(.DIM(2)) u2 (.clk(clk), .rst(rst), .bus(b));

    always #5 clk = ~clk;

    function automatic logic [7:0] dirv(input int dim, input int i);
        logic [7:0] d;
        if (dim == 2) begin
            case (i)
                0: d = 8'h80;
                1: d = 8'hC0;
                2: d = 8'hA0;
                3: d = 8'hF0;
                4: d = 8'h88;
                5: d = 8'hCC;
                6: d = 8'hAA;
                default: d = 8'hFF;
            endcase
        end else begin
            d = 8'h80 >> i;
        end
        return d;
    endfunction

    // n-th Sobol point: XOR of direction vectors selected by gray(n)
    function automatic logic [7:0] seqx(input int dim, input int n);
        int g;
        logic [7:0] xv;
        g  = n ^ (n >> 1);
        xv = 8'd0;
        for (int i = 0; i < 8; i++)
            if (((g >> i) & 1) == 1) xv = xv ^ dirv(dim, i);
        return xv;
    endfunction

    function automatic logic [31:0] word(input int dim, input logic [7:0] v);
        logic [31:0] w;
        for (int k = 0; k < 32; k++) w[k] = v > seqx(dim, k);
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(output int k, output int rl, input bit scr);
        k  = 0;
        rl = 0;
        while (!a.en_out && k < 40) begin
            if (!a.ready) rl++;
            if (scr) a.in = 8'($urandom);
            tick();
            k++;
        end
        chk("en_out_seen", {31'd0, a.en_out}, 32'd1);
        chk("en_out_d2", {31'd0, b.en_out}, 32'd1);
    endtask

    task automatic conv(input logic [7:0] v);
        int k;
        int rl;
        a.en_in = 1'b1;
        a.in    = v;
        tick();
        a.en_in = 1'b0;
        wait_done(k, rl, 1'b1);
        chk("latency", k, 32);
        chk("ready_low", rl, 32);
        chk("word_d1", a.out, word(1, v));
        chk("word_d2", b.out, word(2, v));
    endtask

    task automatic quiet(input int n);
        int hi;
        hi = 0;
        for (int i = 0; i < n; i++) begin
            if (a.en_out || b.en_out) hi++;
            tick();
        end
        chk("no_extra_en_out", hi, 0);
    endtask

    initial begin
        logic [7:0] dv [4];
        int pc [4];
        int k;
        int rl;
        logic [7:0] rv;

        dv = '{8'h80, 8'h00, 8'hFF, 8'h40};
        pc = '{16, 0, 32, 8};

        rst     = 1'b0;
        a.en_in = 1'b0;
        a.in    = 8'h00;
        tick();
        tick();
        chk("rst_ready", {31'd0, a.ready}, 32'd1);
        chk("rst_en_out", {31'd0, a.en_out}, 32'd0);
        chk("rst_out_d1", a.out, 32'd0);
        chk("rst_out_d2", b.out, 32'd0);
        rst = 1'b1;
        tick();

        for (int i = 0; i < 4; i++) begin
            conv(dv[i]);
            chk("popcount", $countones(a.out), pc[i]);
            tick();
            chk("en_out_1cyc", {31'd0, a.en_out}, 32'd0);
            chk("out_hold", a.out, word(1, dv[i]));
            chk("ready_idle", {31'd0, a.ready}, 32'd1);
        end

        repeat (6) begin
            rv = 8'($urandom);
            conv(rv);
            tick();
        end

        // Request during GEN must be ignored
        a.en_in = 1'b1;
        a.in    = 8'h80;
        tick();
        a.en_in = 1'b0;
        repeat (5) tick();
        a.en_in = 1'b1;
        a.in    = 8'h10;
        tick();
        a.en_in = 1'b0;
        wait_done(k, rl, 1'b0);
        chk("ign_latency", k, 26);
        chk("ign_word_d1", a.out, word(1, 8'h80));
        chk("ign_word_d2", b.out, word(2, 8'h80));
        tick();
        quiet(40);

        // Back-to-back with en_in held high
        a.en_in = 1'b1;
        a.in    = 8'h80;
        tick();
        wait_done(k, rl, 1'b0);
        chk("b2b_lat1", k, 32);
        chk("b2b_rdy1", rl, 32);
        chk("b2b_word1", a.out, word(1, 8'h80));
        chk("b2b_pop1", $countones(a.out), 16);
        a.in = 8'h40;
        tick();
        wait_done(k, rl, 1'b0);
        chk("b2b_gap", k + 1, 33);
        chk("b2b_rdy2", rl, 32);
        chk("b2b_word2", a.out, word(1, 8'h40));
        chk("b2b_word2_d2", b.out, word(2, 8'h40));
        chk("b2b_pop2", $countones(a.out), 8);
        a.en_in = 1'b0;
        tick();
        chk("b2b_end", {31'd0, a.en_out}, 32'd0);

        // Reset in the middle of GEN discards the word
        a.en_in = 1'b1;
        a.in    = 8'hFF;
        tick();
        a.en_in = 1'b0;
        repeat (10) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("mid_rst_ready", {31'd0, a.ready}, 32'd1);
        chk("mid_rst_en_out", {31'd0, a.en_out}, 32'd0);
        chk("mid_rst_out_d1", a.out, 32'd0);
        chk("mid_rst_out_d2", b.out, 32'd0);
        quiet(40);
        conv(8'hC3);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
